// File: rtl/pulse_trigger_processor.sv
// ---------------------------------------------------------------------------
// pulse_trigger_processor: pops trigger words, strobes enabled channels,
// collects completions with timeout, emits one readout record.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pulse_trigger_processor #(
   parameter logic [31:0] TIMEOUT = 32'd40000,
   parameter int          NCHAN   = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [127:0]     in_data,
   output logic             in_ready,
   input  logic [NCHAN-1:0] chan_en,
   input  logic [NCHAN-1:0] chan_ready,
   output logic [NCHAN-1:0] acq_trig,
   output logic [1:0]       acq_type,
   input  logic [NCHAN-1:0] acq_done,
   output logic             out_valid,
   output logic [127:0]     out_data,
   input  logic             out_ready,
   output logic [31:0]      trigs_processed,
   output logic [31:0]      timeout_count,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_SEND  = 4'b0010,
      S_WAIT  = 4'b0100,
      S_STORE = 4'b1000
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [43:0]      r_ts;
   logic [23:0]      r_num;
   logic [1:0]       r_len;
   logic [NCHAN-1:0] r_en;
   logic [NCHAN-1:0] r_done;
   logic             r_tflag;
   logic [31:0]      r_timer;
   logic [31:0]      r_trigs;
   logic [31:0]      r_tocount;
   logic             w_gate;
   logic [NCHAN-1:0] w_done_nxt;
   logic             w_complete;
   logic             w_timeout_hit;
   logic             w_unused;

   assign w_unused      = ^in_data[127:70];
   assign w_gate        = ((chan_ready & chan_en) == chan_en);
   assign w_done_nxt    = r_done | (acq_done & r_en);
   assign w_complete    = (w_done_nxt == r_en);
   assign w_timeout_hit = (r_timer == (TIMEOUT - 32'd1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      acq_trig    = '0;
      acq_type    = 2'b00;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = w_gate;
            if (in_valid && w_gate) w_state_nxt = S_SEND;
         end
         S_SEND: begin
            acq_trig    = r_en;
            acq_type    = r_len;
            w_state_nxt = (r_en == '0) ? S_STORE : S_WAIT;
         end
         S_WAIT: begin
            if (w_complete || w_timeout_hit) w_state_nxt = S_STORE;
         end
         S_STORE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ts      <= '0;
         r_num     <= '0;
         r_len     <= '0;
         r_en      <= '0;
         r_done    <= '0;
         r_tflag   <= 1'b0;
         r_timer   <= '0;
         r_trigs   <= '0;
         r_tocount <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && w_gate) begin
                  r_ts    <= in_data[43:0];
                  r_num   <= in_data[67:44];
                  r_len   <= in_data[69:68];
                  r_en    <= chan_en;
                  r_done  <= '0;
                  r_tflag <= 1'b0;
               end
            end
            S_SEND: begin
               r_timer <= '0;
            end
            S_WAIT: begin
               r_done <= w_done_nxt;
               // Completion takes priority over an expiring timer
               if (!w_complete) begin
                  if (w_timeout_hit) begin
                     r_tflag   <= 1'b1;
                     r_tocount <= r_tocount + 32'd1;
                  end else begin
                     r_timer <= r_timer + 32'd1;
                  end
               end
            end
            S_STORE: begin
               if (out_ready) r_trigs <= r_trigs + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_data = out_valid
      ? {{(128 - 71 - 2*NCHAN){1'b0}}, r_tflag, r_done, r_en, r_len, r_num, r_ts}
      : 128'd0;

   assign trigs_processed = r_trigs;
   assign timeout_count   = r_tocount;
   assign state           = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pulse_trigger_processor.sv
// Directed bench for pulse_trigger_processor; records are checked against a queue.
`default_nettype none
`timescale 1ns/1ps

module tb_pulse_trigger_processor;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic [127:0] in_data;
   logic         in_ready;
   logic [4:0]   chan_en;
   logic [4:0]   chan_ready;
   logic [4:0]   acq_trig;
   logic [1:0]   acq_type;
   logic [4:0]   acq_done;
   logic         out_valid;
   logic [127:0] out_data;
   logic         out_ready;
   logic [31:0]  trigs_processed;
   logic [31:0]  timeout_count;
   logic [3:0]   state;

   int           n_cmp = 0;
   int           n_err = 0;
   logic [127:0] sb_q[$];
   logic [127:0] mon_exp;

   pulse_trigger_processor #(.TIMEOUT(32'd16), .NCHAN(5)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_ready        (in_ready),
      .chan_en         (chan_en),
      .chan_ready      (chan_ready),
      .acq_trig        (acq_trig),
      .acq_type        (acq_type),
      .acq_done        (acq_done),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_ready       (out_ready),
      .trigs_processed (trigs_processed),
      .timeout_count   (timeout_count),
      .state           (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk_word(input logic [43:0] ts, input logic [23:0] num,
                                            input logic [1:0] len);
      return {{29{2'b10}}, len, num, ts};
   endfunction

   function automatic logic [127:0] mk_rec(input logic [43:0] ts, input logic [23:0] num,
                                           input logic [1:0] len, input logic [4:0] en,
                                           input logic [4:0] done, input logic flag);
      return {47'd0, flag, done, en, len, num, ts};
   endfunction

   // Record monitor: every handshake must match the oldest expected record
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL unexpected_record observed=%0h expected=none", out_data);
         end else begin
            mon_exp = sb_q.pop_front();
            chk("record", out_data, mon_exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; chan_en = '0;
      chan_ready = '0; acq_done = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 128'(state), 128'h1);
      chk("rst_acq_trig", 128'(acq_trig), 128'h0);
      chk("rst_out_valid", 128'(out_valid), 128'h0);
      chk("rst_out_data", out_data, 128'h0);
      chk("rst_trigs", 128'(trigs_processed), 128'h0);
      chk("rst_tocount", 128'(timeout_count), 128'h0);
      reset_n = 1'b1;

      // Normal trigger, all channels, done 10 cycles after SEND
      chan_en = 5'h1F; chan_ready = 5'h1F;
      tick();
      in_valid = 1'b1; in_data = mk_word(44'h123, 24'd7, 2'b10);
      #1;
      chk("n_in_ready", 128'(in_ready), 128'h1);
      sb_q.push_back(mk_rec(44'h123, 24'd7, 2'b10, 5'h1F, 5'h1F, 1'b0));
      tick();
      in_valid = 1'b0;
      chk("n_send_state", 128'(state), 128'h2);
      chk("n_acq_trig", 128'(acq_trig), 128'h1F);
      chk("n_acq_type", 128'(acq_type), 128'h2);
      tick();
      chk("n_trig_off", 128'(acq_trig), 128'h0);
      chk("n_wait_state", 128'(state), 128'h4);
      repeat (9) tick();
      acq_done = 5'h1F;
      tick();
      acq_done = 5'h00;
      chk("n_store_state", 128'(state), 128'h8);
      chk("n_out_valid", 128'(out_valid), 128'h1);
      tick();
      chk("n_idle_state", 128'(state), 128'h1);
      chk("n_trigs", 128'(trigs_processed), 128'h1);
      chk("n_out_data_idle", out_data, 128'h0);

      // Staggered completions with a stray pulse; fields at their extremes
      chan_en = 5'h05;
      in_valid = 1'b1; in_data = mk_word(44'hFFF_FFFF_FFFF, 24'hFFFFFF, 2'b00);
      sb_q.push_back(mk_rec(44'hFFF_FFFF_FFFF, 24'hFFFFFF, 2'b00, 5'h05, 5'h05, 1'b0));
      tick();
      in_valid = 1'b0;
      chk("s_acq_trig", 128'(acq_trig), 128'h05);
      chk("s_acq_type", 128'(acq_type), 128'h0);
      tick();
      chk("s_wait_state", 128'(state), 128'h4);
      tick(); acq_done = 5'h02;
      tick(); acq_done = 5'h01;
      tick(); acq_done = 5'h00;
      repeat (4) tick();
      chk("s_still_wait", 128'(state), 128'h4);
      acq_done = 5'h04;
      tick();
      acq_done = 5'h00;
      chk("s_store_state", 128'(state), 128'h8);
      tick();
      chk("s_trigs", 128'(trigs_processed), 128'h2);

      // Timeout after exactly 16 WAIT_DONE cycles
      chan_en = 5'h03;
      in_valid = 1'b1; in_data = mk_word(44'hABC, 24'd100, 2'b01);
      sb_q.push_back(mk_rec(44'hABC, 24'd100, 2'b01, 5'h03, 5'h01, 1'b1));
      tick(); in_valid = 1'b0;
      tick(); acq_done = 5'h01;
      tick(); acq_done = 5'h00;
      repeat (14) tick();
      chk("t_wait16", 128'(state), 128'h4);
      tick();
      chk("t_store", 128'(state), 128'h8);
      chk("t_tocount", 128'(timeout_count), 128'h1);
      tick();
      chk("t_trigs", 128'(trigs_processed), 128'h3);

      // Completion on the final timer cycle beats the timeout
      in_valid = 1'b1; in_data = mk_word(44'hABD, 24'd101, 2'b11);
      sb_q.push_back(mk_rec(44'hABD, 24'd101, 2'b11, 5'h03, 5'h03, 1'b0));
      tick(); in_valid = 1'b0;
      tick(); acq_done = 5'h01;
      tick(); acq_done = 5'h00;
      repeat (14) tick();
      acq_done = 5'h02;
      tick();
      acq_done = 5'h00;
      chk("tc_store", 128'(state), 128'h8);
      chk("tc_tocount", 128'(timeout_count), 128'h1);
      tick();
      chk("tc_trigs", 128'(trigs_processed), 128'h4);

      // Channel gating, then backpressure in STORE with a word waiting
      chan_en = 5'h1F; chan_ready = 5'h1E;
      in_valid = 1'b1; in_data = mk_word(44'h55, 24'd200, 2'b10);
      #1;
      chk("g_in_ready_low", 128'(in_ready), 128'h0);
      tick();
      chk("g_no_pop", 128'(state), 128'h1);
      chan_ready = 5'h1F;
      #1;
      chk("g_in_ready_high", 128'(in_ready), 128'h1);
      sb_q.push_back(mk_rec(44'h55, 24'd200, 2'b10, 5'h1F, 5'h1F, 1'b0));
      out_ready = 1'b0;
      tick();
      in_data = mk_word(44'h66, 24'd201, 2'b01);
      tick(); acq_done = 5'h1F;
      tick(); acq_done = 5'h00;
      chk("b_store", 128'(state), 128'h8);
      for (int i = 0; i < 20; i++) begin
         chk("b_out_data_hold", out_data, mk_rec(44'h55, 24'd200, 2'b10, 5'h1F, 5'h1F, 1'b0));
         chk("b_in_ready_hold", 128'(in_ready), 128'h0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("b_idle", 128'(state), 128'h1);

      // Zero channel mask: no strobe, straight to STORE
      chan_en = 5'h00;
      sb_q.push_back(mk_rec(44'h66, 24'd201, 2'b01, 5'h00, 5'h00, 1'b0));
      #1;
      chk("z_in_ready", 128'(in_ready), 128'h1);
      tick();
      in_valid = 1'b0;
      chk("z_send", 128'(state), 128'h2);
      chk("z_acq_trig", 128'(acq_trig), 128'h0);
      tick();
      chk("z_store", 128'(state), 128'h8);
      tick();
      chk("z_trigs", 128'(trigs_processed), 128'h6);

      // Asynchronous reset while waiting for completion
      chan_en = 5'h01;
      in_valid = 1'b1; in_data = mk_word(44'h77, 24'd300, 2'b10);
      tick(); in_valid = 1'b0;
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("r_state", 128'(state), 128'h1);
      chk("r_acq_trig", 128'(acq_trig), 128'h0);
      chk("r_out_valid", 128'(out_valid), 128'h0);
      chk("r_out_data", out_data, 128'h0);
      chk("r_trigs", 128'(trigs_processed), 128'h0);
      chk("r_tocount", 128'(timeout_count), 128'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      acq_done = 5'h01;
      tick();
      acq_done = 5'h00;
      repeat (3) tick();
      chk("r_idle_after", 128'(state), 128'h1);
      chk("r_no_record", 128'(out_valid), 128'h0);
      chan_en = 5'h1F;
      in_valid = 1'b1; in_data = mk_word(44'h88, 24'd301, 2'b11);
      sb_q.push_back(mk_rec(44'h88, 24'd301, 2'b11, 5'h1F, 5'h1F, 1'b0));
      tick();
      in_valid = 1'b0;
      chk("r2_acq_trig", 128'(acq_trig), 128'h1F);
      tick(); acq_done = 5'h1F;
      tick(); acq_done = 5'h00;
      chk("r2_store", 128'(state), 128'h8);
      tick();
      chk("r2_trigs", 128'(trigs_processed), 128'h1);

      repeat (2) tick();
      chk("sb_empty", 128'(sb_q.size()), 128'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pulse_trigger_processor.md
Name: pulse_trigger_processor

Overview:
Consumes 128-bit trigger-info words from the Pulse Trigger FIFO, which is filled by the front-panel trigger receiver. For each word it issues one acquisition strobe per enabled channel and tracks per-channel acquisition completion, with a timeout. It then pushes an annotated trigger record to the readout-info FIFO read by the command manager. Only one trigger is in flight at a time.

Parameters:
TIMEOUT, 40000, max cycles spent in WAIT_DONE (1 ms at 40 MHz); legal range 1..2^32-1
NCHAN, 5, number of channels; fixed at 5, the width of every mask below

Ports:
clk  in  1  40 MHz TTC clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  Pulse Trigger FIFO word available
in_data  in  128  trigger info: [43:0] timestamp, [67:44] trig_num, [69:68] trig_length; [127:70] ignored
in_ready  out  1  pop/accept strobe to Pulse Trigger FIFO
chan_en  in  5  enabled channels, sampled at acceptance
chan_ready  in  5  per-channel ready to acquire
acq_trig  out  5  one-cycle per-channel acquisition strobe
acq_type  out  2  trig_length of the in-flight trigger, valid while acq_trig is high
acq_done  in  5  per-channel acquisition-complete pulse
out_valid  out  1  readout-info record valid
out_data  out  128  readout-info record
out_ready  in  1  readout-info FIFO accepts
trigs_processed  out  32  records stored, wraps
timeout_count  out  32  triggers that timed out, wraps
state  out  4  one-hot FSM state

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all outputs 0, internal latches and timer 0. Reset mid-operation abandons the in-flight trigger with no record; no strobes follow.
- States (one-hot): IDLE=bit0, SEND=bit1, WAIT_DONE=bit2, STORE=bit3.
- IDLE:
  - in_ready = state[IDLE] & ((chan_ready & chan_en) == chan_en).
  - On in_valid & in_ready, latch timestamp, trig_num, trig_length and en_l=chan_en; clear done_l; go to SEND.
  - in_valid alone does not pop.
- SEND, exactly 1 cycle:
  - acq_trig = en_l; acq_type = trig_length. Both are 0 in every other state.
  - Timer cleared to 0.
  - If en_l == 0, no strobe is issued and the next state is STORE (skip WAIT_DONE). Otherwise the next state is WAIT_DONE.
  - First strobe appears the cycle after the acceptance handshake.
- WAIT_DONE:
  - done_l |= acq_done & en_l each cycle. acq_done outside WAIT_DONE, or on non-enabled channels, is ignored.
  - complete = ((done_l | (acq_done & en_l)) == en_l) → STORE, timeout flag = 0.
  - Otherwise, if timer == TIMEOUT-1 → STORE, timeout flag = 1, timeout_count+1. Otherwise timer+1.
  - Completion and final timer value in the same cycle: completion wins, no timeout.
  - WAIT_DONE lasts at most TIMEOUT cycles.
- STORE:
  - out_valid=1; out_data is stable until the handshake.
  - On out_ready: trigs_processed+1, go to IDLE, out_valid=0 the next cycle. Holds indefinitely under backpressure.
- out_data layout:
  - [43:0] timestamp
  - [67:44] trig_num
  - [69:68] trig_length
  - [74:70] en_l
  - [79:75] done_l (final, including the completing cycle)
  - [80] timeout flag
  - [127:81] 0
- out_data is 0 whenever out_valid=0.
- Fields pass through unmodified: trig_length 2'b00 (monitoring disabled) and trig_num wrap are copied as received.
- Minimum trigger period: accept → SEND → WAIT_DONE(≥1) → STORE(≥1) → IDLE, i.e. 4 cycles before the next in_ready.
- Counters are 32-bit and wrap 0xFFFFFFFF→0 silently.

Test Plan:
- Normal: chan_en=5'h1F, all ready, in word num=7, ts=0x123, len=2'b10. acq_done=5'h1F arrives 10 cycles after SEND. Required: acq_trig=5'h1F for 1 cycle the cycle after the pop; record [80:44] fields = timeout 0, done 1F, en 1F, len 2, num 7; ts=0x123; trigs_processed=1.
- Staggered done: chan_en=5'h05, done ch0 at +3, ch2 at +8, stray ch1 done. Required: done_l=5'h05, STORE entered the cycle after the ch2 pulse, stray pulse ignored.
- Timeout: TIMEOUT=16, chan_en=5'h03, only ch0 done. Required: STORE after exactly 16 WAIT_DONE cycles; flag=1; done_l=5'h01; timeout_count=1. Repeat with ch1 done on cycle 16: flag=0, count unchanged.
- Gating/backpressure: chan_ready=5'h1E with chan_en=5'h1F → in_ready=0, no pop. Then out_ready=0 for 20 cycles in STORE → out_data stable, no second pop until out_ready.
- chan_en=0: word popped, no acq_trig; record has en=0, done=0, flag=0, and is stored the cycle after SEND.
- Reset in WAIT_DONE: assert reset_n=0 asynchronously → outputs 0 immediately; after release, no record emitted and the next word is processed normally.
